// File: rtl/l2_pkg.sv
// Types and sizing shared between the L2 responder and the bus controller interface.
package l2_pkg;

  localparam int unsigned BLOCK_SIZE = 2;
  localparam int unsigned DATA_WIDTH = 32 * BLOCK_SIZE;

  typedef logic [31:0]           word_t;
  typedef logic [DATA_WIDTH-1:0] transfer_width_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

endpackage

// File: rtl/l2_mem_array.sv
// Block storage for the L2 responder: synchronous write, combinational read, cleared on reset.
module l2_mem_array #(
  parameter int unsigned NumBlocks = 256,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned IdxW     = $clog2(NumBlocks)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdxW-1:0]      raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [NumBlocks];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumBlocks); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l2_responder.sv
// L2-side responder: decodes block requests, waits LATENCY busy cycles, then answers
// with one L2_ACCESS (or L2_ERROR) cycle.
module l2_responder
  import l2_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 256,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  l2REN,
  input  logic                  l2WEN,
  input  logic [31:0]           l2addr,
  input  logic [DATA_WIDTH-1:0] l2store,
  output logic [DATA_WIDTH-1:0] l2load,
  output l2_state_t             l2state
);

  localparam int unsigned Off  = $clog2(BLOCK_SIZE * 4);
  localparam int unsigned Idx  = $clog2(NUM_BLOCKS);
  localparam int unsigned CntW = $clog2(LATENCY + 1);
  localparam word_t       OffMask = word_t'((64'd1 << Off) - 64'd1);

  l2_state_t             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  op_q, op_d;      // 1: write, 0: read
  logic [Idx-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;

  logic                  misaligned, out_of_range, illegal, active, mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign misaligned   = (l2addr & OffMask) != '0;
  assign out_of_range = (l2addr >> (Off + Idx)) != '0;
  assign illegal      = (l2REN && l2WEN) || misaligned || out_of_range;
  // Only the request line matching the latched op keeps the access alive.
  assign active       = op_q ? l2WEN : l2REN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    data_d  = data_q;
    load_d  = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      L2_FREE: begin
        if (l2REN || l2WEN) begin
          if (illegal) begin
            state_d = L2_ERROR;
          end else begin
            state_d = L2_BUSY;
            op_d    = l2WEN;
            idx_d   = l2addr[Off +: Idx];
            data_d  = l2store;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      L2_BUSY: begin
        if (!active) begin
          state_d = L2_FREE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = L2_ACCESS;
          if (op_q) begin
            mem_we = 1'b1;
          end else begin
            load_d = mem_rdata;
          end
        end
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR:  state_d = L2_FREE;
      default:   state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= L2_FREE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  l2_mem_array #(
    .NumBlocks (NUM_BLOCKS),
    .DataWidth (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (nRST),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (data_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  assign l2load  = load_q;
  assign l2state = state_q;

endmodule

// File: tb/tb_l2_responder.sv
// Randomized scoreboard bench for l2_responder against a block-array reference model.
module tb_l2_responder;
  import l2_pkg::*;

  localparam int unsigned NumBlocks = 256;
  localparam int unsigned Latency   = 4;

  logic                  clk = 1'b0;
  logic                  nRST;
  logic                  l2REN, l2WEN;
  logic [31:0]           l2addr;
  logic [DATA_WIDTH-1:0] l2store, l2load;
  l2_state_t             l2state;

  l2_responder #(
    .NUM_BLOCKS (NumBlocks),
    .LATENCY    (Latency)
  ) dut (
    .clk     (clk),
    .nRST    (nRST),
    .l2REN   (l2REN),
    .l2WEN   (l2WEN),
    .l2addr  (l2addr),
    .l2store (l2store),
    .l2load  (l2load),
    .l2state (l2state)
  );

  always #5 clk = ~clk;

  typedef struct {
    l2_state_t             st;
    logic [DATA_WIDTH-1:0] load;
    int unsigned           cyc;
  } exp_t;

  exp_t                  exp_q[$];
  logic [DATA_WIDTH-1:0] model [NumBlocks];
  int                    checks = 0;
  int                    errors = 0;
  int unsigned           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response cycle is matched against the oldest expectation.
  exp_t e;
  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (l2state == L2_ACCESS || l2state == L2_ERROR) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got state=%s with nothing pending", l2state.name());
        end else begin
          e = exp_q.pop_front();
          if (l2state !== e.st || l2load !== e.load || cyc != e.cyc) begin
            errors++;
            $display("FAIL response: got state=%s load=%h cycle=%0d, expected state=%s load=%h cycle=%0d",
                     l2state.name(), l2load, cyc, e.st.name(), e.load, e.cyc);
          end
        end
      end else begin
        checks++;
        if (l2load !== '0) begin
          errors++;
          $display("FAIL idle_load: got %h in state %s, expected 0", l2load, l2state.name());
        end
      end
    end
  end

  function automatic bit legal(input logic [31:0] addr);
    return (addr % 8 == 0) && (addr < NumBlocks * 8);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(NumBlocks); i++) model[i] = '0;
  endtask

  task automatic drop_req();
    l2REN   = 1'b0;
    l2WEN   = 1'b0;
    l2addr  = $urandom;
    l2store = {$urandom, $urandom};
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [DATA_WIDTH-1:0] data);
    exp_t        x;
    int unsigned idx;
    int          n;
    bit          bad;
    l2_state_t   want;
    @(posedge clk); #1;
    l2REN = ren; l2WEN = wen; l2addr = addr; l2store = data;
    bad = (ren && wen) || !legal(addr);
    if (bad) begin
      x = '{st: L2_ERROR, load: '0, cyc: cyc + 1};
    end else begin
      idx = addr / 8;
      x   = '{st: L2_ACCESS, load: '0, cyc: cyc + Latency + 1};
      if (wen) model[idx] = data;
      else     x.load = model[idx];
    end
    exp_q.push_back(x);
    n = 0;
    forever begin
      @(negedge clk);
      if (l2state == L2_ACCESS || l2state == L2_ERROR || n >= 40) break;
      want = (n == 0) ? L2_FREE : L2_BUSY;
      checks++;
      if (l2state !== want) begin
        errors++;
        $display("FAIL wait_state: step %0d got %s, expected %s", n, l2state.name(), want.name());
      end
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout: no response for addr %h within 40 cycles", addr);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    drop_req();
  endtask

  // Write that is withdrawn during busy cycle k; must return to free with no commit.
  task automatic abort_write(input logic [31:0] addr, input logic [DATA_WIDTH-1:0] data,
                             input int k);
    @(posedge clk); #1;
    l2WEN = 1'b1; l2REN = 1'b0; l2addr = addr; l2store = data;
    repeat (k) @(posedge clk);
    #1 drop_req();
    @(negedge clk);
    checks++;
    if (l2state !== L2_BUSY) begin
      errors++;
      $display("FAIL abort_busy: got %s, expected L2_BUSY", l2state.name());
    end
    @(negedge clk);
    checks++;
    if (l2state !== L2_FREE) begin
      errors++;
      $display("FAIL abort_free: got %s, expected L2_FREE", l2state.name());
    end
  endtask

  task automatic reset_mid_write(input logic [31:0] addr, input logic [DATA_WIDTH-1:0] data);
    @(posedge clk); #1;
    l2WEN = 1'b1; l2addr = addr; l2store = data;
    repeat (2) @(posedge clk);
    #3 nRST = 1'b0;
    #1;
    checks++;
    if (l2state !== L2_FREE || l2load !== '0) begin
      errors++;
      $display("FAIL async_reset: got state=%s load=%h, expected L2_FREE load=0",
               l2state.name(), l2load);
    end
    clear_model();
    drop_req();
    @(negedge clk);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] data;
    int                    r;
    nRST = 1'b0;
    drop_req();
    clear_model();
    #2;
    checks++;
    if (l2state !== L2_FREE || l2load !== '0) begin
      errors++;
      $display("FAIL reset_state: got state=%s load=%h, expected L2_FREE load=0",
               l2state.name(), l2load);
    end
    repeat (3) @(negedge clk);
    nRST = 1'b1;

    issue(1'b1, 1'b0, 32'h0000_0040, '0);
    issue(1'b0, 1'b1, 32'h0000_0080, 64'hDEAD_BEEF_CAFE_F00D);
    issue(1'b1, 1'b0, 32'h0000_0080, '0);
    issue(1'b1, 1'b0, 32'h0000_0088, '0);
    issue(1'b1, 1'b1, 32'h0000_0080, 64'h1234_5678_9ABC_DEF0);
    issue(1'b1, 1'b0, 32'h0000_0080, '0);
    issue(1'b1, 1'b0, 32'h0000_0044, '0);
    issue(1'b1, 1'b0, 32'h0001_0000, '0);
    issue(1'b0, 1'b1, 32'h0000_0044, 64'h5555_AAAA_5555_AAAA);
    issue(1'b0, 1'b1, 32'h0000_0100, 64'h0102_0304_0506_0708);
    abort_write(32'h0000_0100, 64'hFFFF_0000_FFFF_0000, 2);
    issue(1'b1, 1'b0, 32'h0000_0100, '0);
    abort_write(32'h0000_0100, 64'h1111_2222_3333_4444, Latency);
    issue(1'b1, 1'b0, 32'h0000_0100, '0);
    reset_mid_write(32'h0000_0180, 64'hABCD_ABCD_ABCD_ABCD);
    issue(1'b1, 1'b0, 32'h0000_0180, '0);
    issue(1'b1, 1'b0, 32'h0000_0080, '0);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom_range(0, 15) * 8 + $urandom_range(1, 7);
      else if (r == 1) addr = NumBlocks * 8 + $urandom_range(0, 4000) * 8;
      else addr = $urandom_range(0, 15) * 8;
      data = {$urandom, $urandom};
      r = $urandom_range(0, 19);
      if (r == 0) issue(1'b1, 1'b1, addr, data);
      else if (r == 1 && legal(addr)) abort_write(addr, data, $urandom_range(1, Latency));
      else if (r < 10) issue(1'b0, 1'b1, addr, data);
      else issue(1'b1, 1'b0, addr, data);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d responses still expected, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
